// File: rtl/cdm_pkg.sv
// Shared helpers for the carry-disregard multiplier: result width, pipeline latency
// and the partial-product column index.
package cdm_pkg;

  localparam int LATENCY = 3;

  function automatic int rw(input int width);
    return 2 * width + 1;
  endfunction

  // Partial product a[j] & b[i] carries weight 2^(i+j).
  function automatic int col_idx(input int i, input int j);
    return i + j;
  endfunction

endpackage

// File: rtl/cdm_col_reduce.sv
// Combinational column reduction: columns below k are OR-reduced into a low field,
// columns at or above k are summed exactly into two half-sums split by multiplier row.
module cdm_col_reduce
  import cdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [KW-1:0]        k,
  output logic [rw(WIDTH)-1:0] low,
  output logic [rw(WIDTH)-1:0] hi0,
  output logic [rw(WIDTH)-1:0] hi1
);

  localparam int RW = rw(WIDTH);

  // Splitting the high field by row halves the adder depth feeding S2.
  always_comb begin
    low = '0;
    hi0 = '0;
    hi1 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (a[j] & b[i]) begin
          if (col_idx(i, j) < int'(k)) begin
            low = low | (RW'(1) << col_idx(i, j));
          end else if (i < WIDTH / 2) begin
            hi0 = hi0 + (RW'(1) << col_idx(i, j));
          end else begin
            hi1 = hi1 + (RW'(1) << col_idx(i, j));
          end
        end
      end
    end
  end

endmodule

// File: rtl/carry_disregard_mult_pipe.sv
// Three-stage carry-disregard approximate unsigned multiplier with valid/ready and global stall.
// Optional error statistics (out_err, err_cnt) are built when CDM_ERR_STAT_EN is defined.
module carry_disregard_mult_pipe
  import cdm_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [rw(WIDTH)-1:0] out_r
`ifdef CDM_ERR_STAT_EN
  ,
  output logic [rw(WIDTH)-1:0] out_err,
  output logic [31:0]          err_cnt
`endif
);

  localparam int RW = rw(WIDTH);
  localparam int KW = $clog2(2 * WIDTH);

  logic          stall;
  logic          advance;
  logic          vld_p1, vld_p2, vld_p3;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic          approx_p1;
  logic [KW-1:0] k_p1;
  logic [RW-1:0] low_c, hi0_c, hi1_c;
  logic [RW-1:0] low_p2, hi0_p2, hi1_p2;
  logic [RW-1:0] sum_p2;
  logic [RW-1:0] r_p3;

  // A held result freezes every stage; bubbles are kept in place.
  assign stall     = vld_p3 & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = rst | ~stall;
  assign out_valid = vld_p3;
  assign out_r     = r_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // ---- S1: operand capture ----
  always_ff @(posedge clk) begin
    if (advance) begin
      a_p1      <= in_a;
      b_p1      <= in_b;
      approx_p1 <= in_approx;
    end
  end

  // ---- S2: column reduction, exact-mode beats use k = 0 ----
  assign k_p1 = approx_p1 ? KW'(APPROX_COLS) : '0;

  cdm_col_reduce #(
    .WIDTH(WIDTH),
    .KW   (KW)
  ) u_col_reduce (
    .a  (a_p1),
    .b  (b_p1),
    .k  (k_p1),
    .low(low_c),
    .hi0(hi0_c),
    .hi1(hi1_c)
  );

  always_ff @(posedge clk) begin
    if (advance) begin
      low_p2 <= low_c;
      hi0_p2 <= hi0_c;
      hi1_p2 <= hi1_c;
    end
  end

  // ---- S3: final add; low field and high field never overlap in bit position ----
  assign sum_p2 = low_p2 + hi0_p2 + hi1_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p3 <= '0;
    end else if (advance) begin
      r_p3 <= sum_p2;
    end
  end

`ifdef CDM_ERR_STAT_EN
  logic [RW-1:0] exact_p2;
  logic [RW-1:0] err_p3;
  logic [31:0]   cnt_p3;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (advance) begin
      exact_p2 <= RW'(a_p1) * RW'(b_p1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_p3 <= '0;
      cnt_p3 <= '0;
    end else begin
      if (advance) begin
        err_p3 <= exact_p2 - sum_p2;
      end
      if (vld_p3 & out_ready & (|err_p3)) begin
        cnt_p3 <= sat_inc(cnt_p3);
      end
    end
  end

  assign out_err = err_p3;
  assign err_cnt = cnt_p3;
`endif

endmodule
